// File: rtl/callee_share_arbiter_pkg.sv
// rtl/callee_share_arbiter_pkg.sv - state encodings and helpers for callee_share_arbiter
// Shared by the arbiter top and any block that decodes its state.
package call_arb_pkg;

    localparam int STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_DROP    = 2'd1;
    localparam state_t ST_WAIT    = 2'd2;
    localparam state_t ST_RELEASE = 2'd3;

    // Next caller index after idx, wrapping n-1 back to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/callee_share_arbiter_if.sv
// rtl/callee_share_arbiter_if.sv - caller and callee signal bundle for callee_share_arbiter
// master is the arbiter side; slave is the side that owns the callers and the shared callee.
interface callee_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_start;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_done;
    logic [WIDTH-1:0]       req_result;
    logic                   callee_start;
    logic [WIDTH-1:0]       callee_a;
    logic [WIDTH-1:0]       callee_b;
    logic [WIDTH-1:0]       callee_result;
    logic                   callee_done;
    logic                   busy;
    logic [IDX_W-1:0]       grant_idx;

    modport master (
        input  req_start, req_a, req_b, callee_result, callee_done,
        output req_done, req_result, callee_start, callee_a, callee_b, busy, grant_idx
    );

    modport slave (
        output req_start, req_a, req_b, callee_result, callee_done,
        input  req_done, req_result, callee_start, callee_a, callee_b, busy, grant_idx
    );

endinterface

// File: rtl/callee_share_arbiter_picker.sv
// rtl/callee_share_arbiter_picker.sv - combinational grant picker (module rr_priority_picker)
// CALL_ARB_ROUND_ROBIN_EN selects round-robin from ptr; otherwise lowest index wins and ptr is ignored.
module rr_priority_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

`ifdef CALL_ARB_ROUND_ROBIN_EN
    logic [N_REQ-1:0] upper;

    // Requests at or above ptr take precedence; otherwise wrap to the lowest set bit.
    always_comb begin
        upper = '0;
        valid = |req;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            upper[i] = req[i] && (i >= int'(ptr));
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (upper[i]) idx = IDX_W'(i);
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end
`endif

endmodule

// File: rtl/callee_share_arbiter.sv
// rtl/callee_share_arbiter.sv - shares one start/done callee among N_REQ start/done callers
// Define CALL_ARB_ROUND_ROBIN_EN for round-robin grants; the default build is fixed priority.
module callee_share_arbiter
    import call_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    callee_share_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(N_REQ);

    state_t             state;
    logic [IDX_W-1:0]   grant;
    logic [N_REQ-1:0]   done_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               start_q;
    logic               busy_q;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   pick_ptr;
    logic               release_now;

    assign release_now = (state == ST_RELEASE) && !bus.req_start[grant];

`ifdef CALL_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (release_now) begin
            rr_ptr <= IDX_W'(wrap_inc(int'(grant), N_REQ));
        end
    end

    assign pick_ptr = rr_ptr;
`else
    assign pick_ptr = '0;
`endif

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (bus.req_start),
        .ptr   (pick_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // DROP waits for callee_done low so a done level left over from the previous call is never captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant    <= '0;
            done_q   <= '0;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant   <= pick_idx;
                        a_q     <= bus.req_a[int'(pick_idx) * WIDTH +: WIDTH];
                        b_q     <= bus.req_b[int'(pick_idx) * WIDTH +: WIDTH];
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    start_q <= 1'b0;
                    if (!bus.callee_done) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.callee_done) begin
                        result_q      <= bus.callee_result;
                        done_q[grant] <= 1'b1;
                        state         <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (release_now) begin
                        done_q <= '0;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_done     = done_q;
    assign bus.req_result   = result_q;
    assign bus.callee_start = start_q;
    assign bus.callee_a     = a_q;
    assign bus.callee_b     = b_q;
    assign bus.busy         = busy_q;
    assign bus.grant_idx    = grant;

endmodule

// File: tb/tb_callee_share_arbiter.sv
// tb/tb_callee_share_arbiter.sv - directed and randomized bench for callee_share_arbiter
// Expected grant orders follow CALL_ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_callee_share_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    callee_share_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    callee_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int grants[$];

    // Transaction-level model: who owns the callee and how far its call has progressed.
    bit           m_valid = 1'b0;
    int           m_owner;
    bit           m_fresh;
    bit           m_deliv;
    bit           m_start;
    logic [N-1:0] m_done;
    logic [W-1:0] m_res;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    int           m_gidx;
    int           m_g;
`ifdef CALL_ARB_ROUND_ROBIN_EN
    int           m_ptr;
`endif

    function automatic int pick(input logic [N-1:0] r);
`ifdef CALL_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < N; k++) if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
`else
        for (int k = 0; k < N; k++) if (r[k]) return k;
`endif
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_owner = -1;
            m_fresh = 1'b0;
            m_deliv = 1'b0;
            m_start = 1'b0;
            m_done  = '0;
            m_res   = '0;
            m_a     = '0;
            m_b     = '0;
            m_gidx  = 0;
`ifdef CALL_ARB_ROUND_ROBIN_EN
            m_ptr   = 0;
`endif
        end else if (m_valid) begin
            m_start = 1'b0;
            if (m_owner < 0) begin
                m_g = pick(bus.req_start);
                if (m_g >= 0) begin
                    m_owner = m_g;
                    m_gidx  = m_g;
                    m_a     = bus.req_a[m_g*W +: W];
                    m_b     = bus.req_b[m_g*W +: W];
                    m_start = 1'b1;
                    m_fresh = 1'b0;
                    m_deliv = 1'b0;
                end
            end else if (!m_fresh) begin
                m_fresh = !bus.callee_done;
            end else if (!m_deliv) begin
                if (bus.callee_done) begin
                    m_res            = bus.callee_result;
                    m_done[m_owner]  = 1'b1;
                    m_deliv          = 1'b1;
                end
            end else if (!bus.req_start[m_owner]) begin
                m_done  = '0;
`ifdef CALL_ARB_ROUND_ROBIN_EN
                m_ptr   = (m_owner + 1) % N;
`endif
                m_owner = -1;
            end
        end
    end

    // Shared callee: optional stale-done hold, then done low for lat cycles, then done high with a+b.
    int stale_cfg   = 0;
    int lat_cfg     = 3;
    bit rand_callee = 1'b0;

    initial begin : callee_model
        int           stale_left;
        int           lat_left;
        bit           pending;
        logic [W-1:0] res_next;
        bus.callee_done   = 1'b0;
        bus.callee_result = '0;
        stale_left = 0;
        lat_left   = 0;
        pending    = 1'b0;
        res_next   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                bus.callee_done   = 1'b0;
                bus.callee_result = '0;
                pending           = 1'b0;
            end else if (bus.callee_start) begin
                pending    = 1'b1;
                stale_left = rand_callee ? int'($urandom_range(0, 2)) : stale_cfg;
                lat_left   = rand_callee ? int'($urandom_range(1, 4)) : lat_cfg;
                res_next   = bus.callee_a + bus.callee_b;
            end else if (pending) begin
                if (stale_left > 0) begin
                    stale_left--;
                end else if (lat_left > 0) begin
                    bus.callee_done = 1'b0;
                    lat_left--;
                end else begin
                    bus.callee_done   = 1'b1;
                    bus.callee_result = res_next;
                    pending           = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(negedge clk);
        if (m_valid) begin
            check("req_done",     bus.req_done,     m_done);
            check("req_result",   bus.req_result,   m_res);
            check("callee_start", bus.callee_start, m_start);
            check("callee_a",     bus.callee_a,     m_a);
            check("callee_b",     bus.callee_b,     m_b);
            check("busy",         bus.busy,         m_owner >= 0);
            check("grant_idx",    bus.grant_idx,    m_gidx);
            check("done_onehot",  $countones(bus.req_done) <= 1, 1'b1);
        end
    endtask

    task automatic set_req(input int i, input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_start[i]    = s;
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    task automatic wait_start(input int limit, output int g, output int cyc);
        g   = -1;
        cyc = 0;
        while (g < 0 && cyc < limit) begin
            step();
            cyc++;
            if (bus.callee_start) g = int'(bus.grant_idx);
        end
    endtask

    task automatic wait_done(input int i, input int limit, output int cyc);
        cyc = 0;
        while (!bus.req_done[i] && cyc < limit) begin
            step();
            cyc++;
        end
        check("wait_done_timeout", bus.req_done[i], 1'b1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Callers drop on done; with reuse0, caller 0 re-requests until four grants have been seen.
    task automatic serve(input bit reuse0);
        int cyc = 0;
        grants.delete();
        while ((bus.req_start != '0 || bus.busy) && cyc < 400) begin
            step();
            cyc++;
            if (bus.callee_start) grants.push_back(int'(bus.grant_idx));
            for (int i = 0; i < N; i++) begin
                if (bus.req_start[i] && bus.req_done[i])
                    bus.req_start[i] = 1'b0;
                else if (reuse0 && i == 0 && !bus.req_start[0] && !bus.req_done[0] && grants.size() < 4)
                    set_req(0, 1'b1, $urandom, $urandom);
            end
        end
        check("serve_timeout", cyc < 400, 1'b1);
    endtask

    initial begin : stim
        int g;
        int cyc;
        int exp3[$];

        reset         = 1'b1;
        bus.req_start = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_busy",   bus.busy,       0);
        check("rst_done",   bus.req_done,   0);
        check("rst_gidx",   bus.grant_idx,  0);
        check("rst_result", bus.req_result, 0);

        // single caller
        set_req(2, 1'b1, 7, 5);
        wait_start(20, g, cyc);
        check("t1_latency",  cyc, 1);
        check("t1_grant",    g, 2);
        check("t1_callee_a", bus.callee_a, 7);
        check("t1_callee_b", bus.callee_b, 5);
        wait_done(2, 30, cyc);
        check("t1_done",   bus.req_done, 4'b0100);
        check("t1_result", bus.req_result, 12);
        step();
        step();
        check("t1_hold", bus.req_done, 4'b0100);
        set_req(2, 1'b0, 7, 5);
        step();
        check("t1_release_done", bus.req_done, 0);
        check("t1_release_busy", bus.busy, 0);

        // all four at once from reset
        pulse_reset();
        rand_callee = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, $urandom, $urandom);
        serve(1'b0);
        check("t2_count", grants.size(), 4);
        for (int k = 0; k < 4; k++)
            check("t2_order", (k < grants.size()) ? grants[k] : -1, k);

        // caller 0 keeps coming back
        for (int i = 0; i < N; i++) set_req(i, 1'b1, $urandom, $urandom);
        serve(1'b1);
`ifdef CALL_ARB_ROUND_ROBIN_EN
        exp3 = '{0, 1, 2, 3, 0};
`else
        exp3 = '{0, 0, 0, 0, 1, 2, 3};
`endif
        check("t3_count", grants.size(), exp3.size());
        for (int k = 0; k < exp3.size(); k++)
            check("t3_order", (k < grants.size()) ? grants[k] : -1, exp3[k]);

        // stale done held high for two cycles after start
        rand_callee = 1'b0;
        stale_cfg   = 2;
        lat_cfg     = 2;
        set_req(1, 1'b1, 20, 22);
        wait_start(20, g, cyc);
        check("t4_grant", g, 1);
        wait_done(1, 30, cyc);
        check("t4_capture_delay", cyc, 6);
        check("t4_result", bus.req_result, 42);
        set_req(1, 1'b0, 20, 22);
        step();

        // reset while waiting on the callee
        stale_cfg = 0;
        lat_cfg   = 5;
        set_req(3, 1'b1, 1, 2);
        wait_start(20, g, cyc);
        check("t5_grant", g, 3);
        step();
        step();
        pulse_reset();
        check("t5_rst_busy",   bus.busy,         0);
        check("t5_rst_done",   bus.req_done,     0);
        check("t5_rst_start",  bus.callee_start, 0);
        check("t5_rst_a",      bus.callee_a,     0);
        check("t5_rst_gidx",   bus.grant_idx,    0);
        check("t5_rst_result", bus.req_result,   0);
        wait_start(20, g, cyc);
        check("t5_regrant_latency", cyc, 1);
        check("t5_regrant", g, 3);
        wait_done(3, 30, cyc);
        check("t5_result", bus.req_result, 3);
        set_req(3, 1'b0, 1, 2);
        step();

        // operand change after grant
        set_req(1, 1'b1, 9, 1);
        wait_start(20, g, cyc);
        check("t6_grant", g, 1);
        check("t6_a_grant", bus.callee_a, 9);
        step();
        step();
        set_req(1, 1'b1, 3, 1);
        step();
        step();
        check("t6_a_hold", bus.callee_a, 9);
        wait_done(1, 30, cyc);
        check("t6_result", bus.req_result, 10);
        set_req(1, 1'b0, 3, 1);
        step();

        // random callers, callee timing and occasional reset
        rand_callee = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < N; i++) begin
                if (bus.req_start[i] && bus.req_done[i]) begin
                    if ($urandom_range(0, 2) != 0) bus.req_start[i] = 1'b0;
                end else if (!bus.req_start[i] && !bus.req_done[i]) begin
                    if ($urandom_range(0, 3) == 0) set_req(i, 1'b1, $urandom, $urandom);
                end else if (bus.req_start[i] && $urandom_range(0, 7) == 0) begin
                    bus.req_a[i*W +: W] = $urandom;
                    bus.req_b[i*W +: W] = $urandom;
                end
            end
            step();
        end
        reset = 1'b0;
        serve(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
